// File: rtl/ex_divider_pkg.sv
// Shared definitions for the EX-stage iterative divider: bus width, FSM
// encoding, latched operand attributes and sign helpers.
package ex_divider_pkg;

    localparam int DATA_BUS  = 32;
    localparam int DIV_STEPS = DATA_BUS;
    localparam int CNT_W     = 6;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_ZERO = 2'd1,
        BUSY     = 2'd2,
        DONE     = 2'd3
    } div_state_t;

    typedef struct packed {
        logic is_signed;
        logic dividend_neg;
        logic divisor_neg;
    } op_flags_t;

    // Two's-complement magnitude; in unsigned mode the operand is already one.
    function automatic logic [DATA_BUS-1:0] magnitude(input logic [DATA_BUS-1:0] value,
                                                      input logic                is_signed);
        return (is_signed && value[DATA_BUS-1]) ? (~value + DATA_BUS'(1)) : value;
    endfunction

    function automatic logic [DATA_BUS-1:0] cond_negate(input logic [DATA_BUS-1:0] value,
                                                        input logic                negate);
        return negate ? (~value + DATA_BUS'(1)) : value;
    endfunction

endpackage

// File: rtl/ex_divider_div_step.sv
// One restoring-division iteration on the packed {remainder, quotient} word:
// shift left, trial-subtract the divisor, keep the difference if it fits.
module div_step
    import ex_divider_pkg::*;
(
    input  logic [2*DATA_BUS-1:0] rq_in,
    input  logic [DATA_BUS-1:0]   divisor,
    output logic [2*DATA_BUS-1:0] rq_out
);

    // The shifted partial remainder needs one extra bit: it can reach 2*divisor-1.
    logic [DATA_BUS:0] partial;
    logic [DATA_BUS:0] diff;

    assign partial = rq_in[2*DATA_BUS-1:DATA_BUS-1];
    assign diff    = partial - {1'b0, divisor};

    always_comb begin
        if (diff[DATA_BUS]) begin
            rq_out = {partial[DATA_BUS-1:0], rq_in[DATA_BUS-2:0], 1'b0};
        end else begin
            rq_out = {diff[DATA_BUS-1:0], rq_in[DATA_BUS-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/ex_divider.sv
// Multi-cycle DIV/DIVU unit for the EX stage: 32 restoring iterations on
// operand magnitudes, sign fix-up registered on completion, pipeline stall.
module ex_divider
    import ex_divider_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                signed_div,
    input  logic [DATA_BUS-1:0] dividend,
    input  logic [DATA_BUS-1:0] divisor,
    input  logic                ack,
    input  logic                annul,
    output logic                stall_request,
    output logic                done,
    output logic [DATA_BUS-1:0] result_lo,
    output logic [DATA_BUS-1:0] result_hi
);

    div_state_t            state;
    logic [CNT_W-1:0]      count;
    logic [2*DATA_BUS-1:0] rq;
    logic [2*DATA_BUS-1:0] rq_next;
    logic [DATA_BUS-1:0]   divisor_mag;
    op_flags_t             flags;

    logic                  neg_quot;
    logic                  neg_rem;
    logic [DATA_BUS-1:0]   quot_fixed;
    logic [DATA_BUS-1:0]   rem_fixed;

    div_step u_div_step (
        .rq_in   (rq),
        .divisor (divisor_mag),
        .rq_out  (rq_next)
    );

    // Fix-up is applied to the last iteration's output and captured in the
    // same edge that enters DONE, so results never see the live operands.
    assign neg_quot   = flags.is_signed & (flags.dividend_neg ^ flags.divisor_neg);
    assign neg_rem    = flags.is_signed & flags.dividend_neg;
    assign quot_fixed = cond_negate(rq_next[DATA_BUS-1:0], neg_quot);
    assign rem_fixed  = cond_negate(rq_next[2*DATA_BUS-1:DATA_BUS], neg_rem);

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        stall_request = 1'b0;
        case (state)
            IDLE:     stall_request = start & ~annul;
            DIV_ZERO: stall_request = 1'b1;
            BUSY:     stall_request = 1'b1;
            default:  stall_request = 1'b0;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            rq          <= '0;
            divisor_mag <= '0;
            flags       <= '0;
            done        <= 1'b0;
            result_lo   <= '0;
            result_hi   <= '0;
        end else if (annul) begin
            state <= IDLE;
            count <= '0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        count <= '0;
                        flags <= '{is_signed:    signed_div,
                                   dividend_neg: dividend[DATA_BUS-1],
                                   divisor_neg:  divisor[DATA_BUS-1]};
                        if (divisor == '0) begin
                            // Raw dividend is kept: it becomes the remainder.
                            rq          <= {{DATA_BUS{1'b0}}, dividend};
                            divisor_mag <= '0;
                            state       <= DIV_ZERO;
                        end else begin
                            rq          <= {{DATA_BUS{1'b0}}, magnitude(dividend, signed_div)};
                            divisor_mag <= magnitude(divisor, signed_div);
                            state       <= BUSY;
                        end
                    end
                end

                DIV_ZERO: begin
                    result_lo <= '1;
                    result_hi <= rq[DATA_BUS-1:0];
                    done      <= 1'b1;
                    state     <= DONE;
                end

                BUSY: begin
                    rq    <= rq_next;
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(DIV_STEPS - 1)) begin
                        result_lo <= quot_fixed;
                        result_hi <= rem_fixed;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end

                DONE: begin
                    // start is deliberately ignored here: the instruction
                    // that produced this result must not relaunch.
                    if (ack) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_divider.sv
// Scoreboard bench for ex_divider: expected {hi, lo} pushed at issue, popped
// and compared when done rises; latency, stall, hold, annul and reset covered.
module tb_ex_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        ack;
    logic        annul;
    logic        stall_request;
    logic        done;
    logic [31:0] result_lo;
    logic [31:0] result_hi;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] exp_q[$];

    ex_divider dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .signed_div    (signed_div),
        .dividend      (dividend),
        .divisor       (divisor),
        .ack           (ack),
        .annul         (annul),
        .stall_request (stall_request),
        .done          (done),
        .result_lo     (result_lo),
        .result_hi     (result_hi)
    );

    always #5 clk = ~clk;

    // Reference: {remainder, quotient} from the language's own operators.
    function automatic logic [63:0] model(input logic sd, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        int q;
        int r;
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (!sd) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa = a;
        sb = b;
        q  = sa / sb;
        r  = sa % sb;
        return {32'(r), 32'(q)};
    endfunction

    // Called just after a falling edge: this cycle becomes cycle 0.
    task automatic issue(input logic sd, input logic [31:0] a, input logic [31:0] b, input bit push);
        if (push) exp_q.push_back(model(sd, a, b));
        signed_div = sd;
        dividend   = a;
        divisor    = b;
        start      = 1'b1;
    endtask

    // Walks cycles from cycle 0 until done, checking stall and latency, then
    // pops the scoreboard. Returns in the first done cycle without acking.
    task automatic wait_done(input string name, input int exp_lat);
        int cyc   = 0;
        bit seen  = 0;
        bit stall_ok = 1;
        logic [63:0] exp;
        while (!seen && cyc < 60) begin
            #1;
            if (done === 1'b1) begin
                seen = 1;
            end else begin
                if (stall_request !== 1'b1) stall_ok = 0;
                @(negedge clk);
                cyc++;
                // Scramble operands: the divider must work from latched copies.
                if (cyc == 1) begin
                    dividend = $urandom;
                    divisor  = $urandom;
                end
            end
        end
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL %s timeout: done not seen within %0d cycles", name, cyc);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        if (cyc != exp_lat) begin
            n_errors++;
            $display("FAIL %s latency: got %0d cycles, expected %0d", name, cyc, exp_lat);
        end
        n_checks++;
        if (!stall_ok) begin
            n_errors++;
            $display("FAIL %s stall: stall_request low before done, expected high on cycles 0-%0d", name, exp_lat - 1);
        end
        n_checks++;
        if (stall_request !== 1'b0) begin
            n_errors++;
            $display("FAIL %s stall_in_done: got %b, expected 0", name, stall_request);
        end
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s scoreboard: result with empty queue lo=%h hi=%h", name, result_lo, result_hi);
        end else begin
            exp = exp_q.pop_front();
            if (result_lo !== exp[31:0] || result_hi !== exp[63:32]) begin
                n_errors++;
                $display("FAIL %s result: got lo=%h hi=%h, expected lo=%h hi=%h",
                         name, result_lo, result_hi, exp[31:0], exp[63:32]);
            end
        end
    endtask

    task automatic finish_ack(input string name);
        ack   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        ack = 1'b0;
        #1;
        n_checks++;
        if (done !== 1'b0) begin
            n_errors++;
            $display("FAIL %s ack_release: done got %b, expected 0", name, done);
        end
    endtask

    task automatic run_div(input string name, input logic sd, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        issue(sd, a, b, 1);
        wait_done(name, (b == 32'h0) ? 2 : 33);
        finish_ack(name);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || result_lo !== 32'h0 || result_hi !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_outputs: got done=%b lo=%h hi=%h, expected 0/0/0", done, result_lo, result_hi);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (stall_request !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_stall: got %b, expected 0", stall_request);
        end
    endtask

    task automatic test_basic();
        run_div("divu_100_7", 1'b0, 32'd100, 32'd7);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_div("div_m1_m1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
        run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
        run_div("divu_3_9", 1'b0, 32'd3, 32'd9);
        run_div("divu_max_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    endtask

    task automatic test_div_zero();
        run_div("divu_5_0", 1'b0, 32'd5, 32'd0);
        run_div("div_m3_0", 1'b1, 32'hFFFF_FFFD, 32'd0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic        sd;
        for (int i = 0; i < 6; i++) begin
            a  = $urandom;
            b  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (b == 32'h0) b = 32'd3;
            sd = 1'($urandom_range(0, 1));
            run_div($sformatf("rand_%0d", i), sd, a, b);
        end
    endtask

    task automatic test_annul();
        logic [31:0] lo_before;
        logic [31:0] hi_before;
        bit          done_seen = 0;
        lo_before = result_lo;
        hi_before = result_hi;
        @(negedge clk);
        issue(1'b0, 32'd100, 32'd7, 0);
        repeat (10) @(negedge clk);
        annul = 1'b1;
        start = 1'b0;
        @(negedge clk);
        annul = 1'b0;
        #1;
        n_checks++;
        if (stall_request !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL annul_idle: got stall=%b done=%b, expected 0/0", stall_request, done);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done !== 1'b0) done_seen = 1;
        end
        n_checks++;
        if (done_seen || result_lo !== lo_before || result_hi !== hi_before) begin
            n_errors++;
            $display("FAIL annul_no_result: done_seen=%0d lo=%h hi=%h, expected 0 lo=%h hi=%h",
                     done_seen, result_lo, result_hi, lo_before, hi_before);
        end
        run_div("divu_9_3_after_annul", 1'b0, 32'd9, 32'd3);
    endtask

    task automatic test_ack_hold();
        logic [31:0] lo_saved;
        logic [31:0] hi_saved;
        bit          hold_ok = 1;
        @(negedge clk);
        issue(1'b0, 32'd1234, 32'd10, 1);
        wait_done("ack_hold", 33);
        lo_saved = result_lo;
        hi_saved = result_hi;
        for (int i = 0; i < 5; i++) begin
            ack      = 1'b0;
            start    = 1'b1;
            dividend = 32'd77;
            divisor  = 32'd0;
            @(negedge clk);
            #1;
            if (done !== 1'b1 || result_lo !== lo_saved || result_hi !== hi_saved || stall_request !== 1'b0)
                hold_ok = 0;
        end
        n_checks++;
        if (!hold_ok) begin
            n_errors++;
            $display("FAIL ack_hold_stable: got done=%b lo=%h hi=%h stall=%b, expected 1 lo=%h hi=%h 0",
                     done, result_lo, result_hi, stall_request, lo_saved, hi_saved);
        end
        finish_ack("ack_hold");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        issue(1'b0, 32'd1000, 32'd33, 1);
        wait_done("b2b_first", 33);
        // Acknowledge while already presenting the next instruction.
        ack = 1'b1;
        issue(1'b1, 32'hFFFF_FC18, 32'd7, 1);
        @(negedge clk);
        ack = 1'b0;
        #1;
        n_checks++;
        if (done !== 1'b0 || stall_request !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_gap: got done=%b stall=%b, expected 0/1", done, stall_request);
        end
        wait_done("b2b_second", 33);
        finish_ack("b2b_second");
    endtask

    task automatic test_reset_mid_busy();
        bit done_seen = 0;
        @(negedge clk);
        issue(1'b1, 32'hFFFF_FF00, 32'd3, 0);
        repeat (15) @(negedge clk);
        rst   = 1'b1;
        annul = 1'b1;
        ack   = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        annul = 1'b0;
        ack   = 1'b0;
        start = 1'b0;
        #1;
        n_checks++;
        if (done !== 1'b0 || result_lo !== 32'h0 || result_hi !== 32'h0 || stall_request !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_busy: got done=%b lo=%h hi=%h stall=%b, expected all 0",
                     done, result_lo, result_hi, stall_request);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || result_lo !== 32'h0 || result_hi !== 32'h0) done_seen = 1;
        end
        n_checks++;
        if (done_seen) begin
            n_errors++;
            $display("FAIL reset_no_late_result: got done=%b lo=%h hi=%h, expected all 0", done, result_lo, result_hi);
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        signed_div = 1'b0;
        dividend   = 32'h0;
        divisor    = 32'h0;
        ack        = 1'b0;
        annul      = 1'b0;

        test_reset();
        test_basic();
        test_div_zero();
        test_random();
        test_annul();
        test_ack_hold();
        test_back_to_back();
        test_reset_mid_busy();

        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
